// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit ALU: width, unit selects, function codes, compare codes.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  // Unit select, taken from ALU_FUN[3:2]
  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  // Arithmetic unit
  localparam logic [3:0] FUN_ADD  = 4'b0000;
  localparam logic [3:0] FUN_SUB  = 4'b0001;
  localparam logic [3:0] FUN_MUL  = 4'b0010;
  localparam logic [3:0] FUN_DIV  = 4'b0011;
  // Logic unit
  localparam logic [3:0] FUN_AND  = 4'b0100;
  localparam logic [3:0] FUN_OR   = 4'b0101;
  localparam logic [3:0] FUN_NAND = 4'b0110;
  localparam logic [3:0] FUN_NOR  = 4'b0111;
  // Compare unit
  localparam logic [3:0] FUN_CNOP = 4'b1000;
  localparam logic [3:0] FUN_CEQ  = 4'b1001;
  localparam logic [3:0] FUN_CGT  = 4'b1010;
  localparam logic [3:0] FUN_CLT  = 4'b1011;
  // Shift unit
  localparam logic [3:0] FUN_SRA1 = 4'b1100;
  localparam logic [3:0] FUN_SLA1 = 4'b1101;
  localparam logic [3:0] FUN_SRB1 = 4'b1110;
  localparam logic [3:0] FUN_SLB1 = 4'b1111;

  // Compare result codes (zero-extended onto CMP_Out)
  localparam logic [1:0] CMP_NONE = 2'd0;
  localparam logic [1:0] CMP_EQ   = 2'd1;
  localparam logic [1:0] CMP_GT   = 2'd2;
  localparam logic [1:0] CMP_LT   = 2'd3;

  // Unit field of a function code
  function automatic logic [1:0] unit_of(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Unit decoder: function-code unit field to a one-hot enable (bit0 arith .. bit3 shift).
module alu_decoder
  import alu_pkg::*;
(
  input  logic [3:0] alu_fun,
  output logic [3:0] en_c
);

  // One-hot decode of the unit field
  always_comb begin
    en_c = '0;
    case (unit_of(alu_fun))
      ARITH:   en_c[0] = 1'b1;
      LOGIC:   en_c[1] = 1'b1;
      CMP:     en_c[2] = 1'b1;
      SHIFT:   en_c[3] = 1'b1;
      default: en_c    = '0;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// Signed ALU with arithmetic, logic, compare and shift units, one-cycle registered results.
// Optional divider on code 0011 is built only when ALU_DIV_EN is defined; otherwise 0011 gives 0.
module alu_top
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic        [3:0]       ALU_FUN,
  output logic signed [WIDTH-1:0] Arith_Out,
  output logic                    Arith_Flag,
  output logic        [WIDTH-1:0] Logic_Out,
  output logic                    Logic_Flag,
  output logic        [WIDTH-1:0] CMP_Out,
  output logic                    CMP_Flag,
  output logic        [WIDTH-1:0] Shift_Out,
  output logic                    Shift_Flag
);

  logic        [3:0]       en_c;
  logic signed [WIDTH-1:0] div_c;
  logic signed [WIDTH-1:0] arith_c;
  logic        [WIDTH-1:0] logic_c;
  logic        [1:0]       cmp_code_c;
  logic        [WIDTH-1:0] shift_c;

  alu_decoder u_decoder (
    .alu_fun (ALU_FUN),
    .en_c    (en_c)
  );

  // Signed divide, truncating toward zero; zero divisor and the -1 divisor handled explicitly
`ifdef ALU_DIV_EN
  always_comb begin
    div_c = '0;
    if (B == '0) begin
      div_c = '0;
    end else if (B == '1) begin
      div_c = -A;  // most-negative / -1 wraps back to most-negative
    end else begin
      div_c = A / B;
    end
  end
`else
  assign div_c = '0;
`endif

  // Arithmetic next value; add/sub/mul keep the low WIDTH bits (wrap)
  always_comb begin
    arith_c = '0;
    case (ALU_FUN)
      FUN_ADD: arith_c = A + B;
      FUN_SUB: arith_c = A - B;
      FUN_MUL: arith_c = A * B;
      FUN_DIV: arith_c = div_c;
      default: arith_c = '0;
    endcase
  end

  // Logic next value
  always_comb begin
    logic_c = '0;
    case (ALU_FUN)
      FUN_AND:  logic_c = A & B;
      FUN_OR:   logic_c = A | B;
      FUN_NAND: logic_c = ~(A & B);
      FUN_NOR:  logic_c = ~(A | B);
      default:  logic_c = '0;
    endcase
  end

  // Signed compare result code
  always_comb begin
    cmp_code_c = CMP_NONE;
    case (ALU_FUN)
      FUN_CNOP: cmp_code_c = CMP_NONE;
      FUN_CEQ:  cmp_code_c = (A == B) ? CMP_EQ : CMP_NONE;
      FUN_CGT:  cmp_code_c = (A > B)  ? CMP_GT : CMP_NONE;
      FUN_CLT:  cmp_code_c = (A < B)  ? CMP_LT : CMP_NONE;
      default:  cmp_code_c = CMP_NONE;
    endcase
  end

  // Logical one-bit shifts, zero fill (sign bit is not kept)
  always_comb begin
    shift_c = '0;
    case (ALU_FUN)
      FUN_SRA1: shift_c = A >> 1;
      FUN_SLA1: shift_c = A << 1;
      FUN_SRB1: shift_c = B >> 1;
      FUN_SLB1: shift_c = B << 1;
      default:  shift_c = '0;
    endcase
  end

  // Arithmetic unit register; cleared whenever another unit is selected
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Arith_Out  <= '0;
      Arith_Flag <= 1'b0;
    end else if (en_c[0]) begin
      Arith_Out  <= arith_c;
      Arith_Flag <= 1'b1;
    end else begin
      Arith_Out  <= '0;
      Arith_Flag <= 1'b0;
    end
  end

  // Logic unit register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Logic_Out  <= '0;
      Logic_Flag <= 1'b0;
    end else if (en_c[1]) begin
      Logic_Out  <= logic_c;
      Logic_Flag <= 1'b1;
    end else begin
      Logic_Out  <= '0;
      Logic_Flag <= 1'b0;
    end
  end

  // Compare unit register; code zero-extended to WIDTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      CMP_Out  <= '0;
      CMP_Flag <= 1'b0;
    end else if (en_c[2]) begin
      CMP_Out  <= WIDTH'(cmp_code_c);
      CMP_Flag <= 1'b1;
    end else begin
      CMP_Out  <= '0;
      CMP_Flag <= 1'b0;
    end
  end

  // Shift unit register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Shift_Out  <= '0;
      Shift_Flag <= 1'b0;
    end else if (en_c[3]) begin
      Shift_Out  <= shift_c;
      Shift_Flag <= 1'b1;
    end else begin
      Shift_Out  <= '0;
      Shift_Flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Directed self-checking bench for alu_top; divide expectations follow ALU_DIV_EN.
module tb_alu_top;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  logic                clk;
  logic                rst;
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic        [3:0]   ALU_FUN;
  logic signed [W-1:0] Arith_Out;
  logic                Arith_Flag;
  logic        [W-1:0] Logic_Out;
  logic                Logic_Flag;
  logic        [W-1:0] CMP_Out;
  logic                CMP_Flag;
  logic        [W-1:0] Shift_Out;
  logic                Shift_Flag;

  int errors = 0;
  int checks = 0;

  alu_top #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .Arith_Out  (Arith_Out),
    .Arith_Flag (Arith_Flag),
    .Logic_Out  (Logic_Out),
    .Logic_Flag (Logic_Flag),
    .CMP_Out    (CMP_Out),
    .CMP_Flag   (CMP_Flag),
    .Shift_Out  (Shift_Out),
    .Shift_Flag (Shift_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected quotient depends on whether the divider is built
  function automatic logic [W-1:0] div_exp(input logic [W-1:0] q);
`ifdef ALU_DIV_EN
    return q;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all eight outputs: unit u (0..3, or -1 for none) holds val with flag set, rest zero
  task automatic chk_all(input string tag, input int u, input logic [W-1:0] val);
    chk({tag, " arith_out"},  Arith_Out,          (u == 0) ? val : '0);
    chk({tag, " arith_flag"}, W'(Arith_Flag),     W'(u == 0));
    chk({tag, " logic_out"},  Logic_Out,          (u == 1) ? val : '0);
    chk({tag, " logic_flag"}, W'(Logic_Flag),     W'(u == 1));
    chk({tag, " cmp_out"},    CMP_Out,            (u == 2) ? val : '0);
    chk({tag, " cmp_flag"},   W'(CMP_Flag),       W'(u == 2));
    chk({tag, " shift_out"},  Shift_Out,          (u == 3) ? val : '0);
    chk({tag, " shift_flag"}, W'(Shift_Flag),     W'(u == 3));
  endtask

  // Present one operation and sample just after the capturing edge
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun);
    @(negedge clk);
    A = a;
    B = b;
    ALU_FUN = fun;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    A = 16'sd5;
    B = 16'sd3;
    ALU_FUN = FUN_ADD;

    // Reset held with live inputs: everything stays zero
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_hold", -1, '0);

    // Release; first edge samples 5+3
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset_release", 0, 16'd8);

    // Arithmetic
    op(-16'sd10, -16'sd5, FUN_ADD);  chk_all("add_neg", 0, 16'hFFF1);
    op(16'sd10,  16'sd5,  FUN_SUB);  chk_all("sub", 0, 16'd5);
    op(16'sd3,   16'sd4,  FUN_MUL);  chk_all("mul", 0, 16'd12);
    op(-16'sd3,  16'sd4,  FUN_MUL);  chk_all("mul_neg", 0, 16'hFFF4);
    op(16'sd20,  16'sd4,  FUN_DIV);  chk_all("div", 0, div_exp(16'd5));
    op(-16'sd7,  16'sd2,  FUN_DIV);  chk_all("div_trunc", 0, div_exp(16'hFFFD));
    op(16'sd7,   16'sd0,  FUN_DIV);  chk_all("div_zero", 0, 16'd0);
    op(16'h8000, 16'hFFFF, FUN_DIV); chk_all("div_min_m1", 0, div_exp(16'h8000));
    op(16'sd32767, 16'sd1, FUN_ADD); chk_all("add_ovf", 0, 16'h8000);
    op(16'h8000, 16'sd1,  FUN_SUB);  chk_all("sub_ovf", 0, 16'h7FFF);

    // Logic
    op(16'sd6, 16'sd3, FUN_AND);  chk_all("and", 1, 16'd2);
    op(16'sd6, 16'sd3, FUN_OR);   chk_all("or", 1, 16'd7);
    op(16'sd6, 16'sd3, FUN_NAND); chk_all("nand", 1, 16'hFFFD);
    op(16'sd6, 16'sd3, FUN_NOR);  chk_all("nor", 1, 16'hFFF8);

    // Compare
    op(16'sd6,  16'sd6,  FUN_CNOP); chk_all("cmp_nop", 2, 16'd0);
    op(16'sd6,  16'sd6,  FUN_CEQ);  chk_all("cmp_eq", 2, 16'd1);
    op(16'sd5,  16'sd1,  FUN_CGT);  chk_all("cmp_gt", 2, 16'd2);
    op(16'sd7,  16'sd11, FUN_CLT);  chk_all("cmp_lt", 2, 16'd3);
    op(-16'sd1, 16'sd1,  FUN_CGT);  chk_all("cmp_gt_signed", 2, 16'd0);
    op(-16'sd1, 16'sd1,  FUN_CLT);  chk_all("cmp_lt_signed", 2, 16'd3);
    op(16'sd5,  16'sd6,  FUN_CEQ);  chk_all("cmp_ne", 2, 16'd0);

    // Shift
    op(16'sd4,  16'sd0, FUN_SRA1); chk_all("shr_a", 3, 16'd2);
    op(16'sd8,  16'sd0, FUN_SLA1); chk_all("shl_a", 3, 16'd16);
    op(16'sd0,  16'sd1, FUN_SRB1); chk_all("shr_b", 3, 16'd0);
    op(16'sd0,  16'sd1, FUN_SLB1); chk_all("shl_b", 3, 16'd2);
    op(-16'sd2, 16'sd0, FUN_SRA1); chk_all("shr_neg", 3, 16'h7FFF);
    op(16'h8001, 16'sd0, FUN_SLA1); chk_all("shl_msb", 3, 16'd2);

    // Back-to-back unit switching, one op per cycle
    op(16'sd9,  16'sd4,  FUN_SUB);  chk_all("b2b_arith", 0, 16'd5);
    op(16'sd12, 16'sd10, FUN_OR);   chk_all("b2b_logic", 1, 16'd14);
    op(16'sd3,  16'sd3,  FUN_CEQ);  chk_all("b2b_cmp", 2, 16'd1);
    op(16'sd1,  16'sd7,  FUN_SLB1); chk_all("b2b_shift", 3, 16'd14);
    op(16'sd2,  16'sd2,  FUN_MUL);  chk_all("b2b_arith2", 0, 16'd4);
    op(16'sd2,  16'sd5,  FUN_CLT);  chk_all("b2b_cmp2", 2, 16'd3);

    // Asynchronous reset mid-cycle clears outputs without an edge
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_reset", -1, '0);

    // Release with new inputs already present: first edge samples them
    @(negedge clk);
    A = 16'sd6;
    B = 16'sd3;
    ALU_FUN = FUN_AND;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rerelease", 1, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- 16-bit signed ALU with four execution units: arithmetic, logic, compare and shift.
- A 4-bit function code selects the unit (ALU_FUN[3:2]) and the operation within it (ALU_FUN[1:0]).
- Each unit has its own registered result and valid flag.
- Datapath leaf block, driven by a controller that presents operands and function code each cycle.

Parameters:
- WIDTH, 16, operand and result width (two's complement).

Ports:
- clk      in   1      rising-edge clock
- rst      in   1      asynchronous active-low reset
- A        in   WIDTH  signed operand A
- B        in   WIDTH  signed operand B
- ALU_FUN  in   4      function code
- Arith_Out   out  WIDTH  arithmetic result (signed)
- Arith_Flag  out  1      arithmetic unit selected last cycle
- Logic_Out   out  WIDTH  logic result
- Logic_Flag  out  1      logic unit selected last cycle
- CMP_Out     out  WIDTH  compare result code
- CMP_Flag    out  1      compare unit selected last cycle
- Shift_Out   out  WIDTH  shift result
- Shift_Flag  out  1      shift unit selected last cycle

Behaviour:
- Reset: rst low asynchronously clears all eight outputs to 0. They stay 0 while rst is low.
- Latency: one cycle. A, B and ALU_FUN are sampled at a rising edge; results are valid after that edge. No handshake; a new operation may start every cycle.
- Unit decode on ALU_FUN[3:2]:
  - 00 arithmetic, 01 logic, 10 compare, 11 shift.
  - Exactly one unit's flag is 1 each cycle after reset.
  - Each non-selected unit's output and flag register to 0 that cycle.
- Arithmetic unit:
  - 0000: A+B
  - 0001: A-B
  - 0010: A*B, low WIDTH bits of the signed product
  - 0011: A/B, signed, truncated toward zero
  - Add/sub overflow wraps modulo 2^WIDTH.
  - Divide by zero gives 0.
  - -32768/-1 gives -32768 (wrap).
- Logic unit:
  - 0100: A&B
  - 0101: A|B
  - 0110: ~(A&B)
  - 0111: ~(A|B)
- Compare unit (signed comparison); result code zero-extended to WIDTH:
  - 1000: no-op, 0
  - 1001: 1 if A==B else 0
  - 1010: 2 if A>B else 0
  - 1011: 3 if A<B else 0
- Shift unit (logical shifts by one, zero fill; the sign bit is not preserved):
  - 1100: A>>1
  - 1101: A<<1
  - 1110: B>>1
  - 1111: B<<1
- Reset deasserted mid-stream: the first edge after release samples the current inputs normally.

Optional Feature:
- Macro ALU_DIV_EN.
  - Defined: code 0011 performs signed division as above.
  - Undefined: no divider is synthesised. Code 0011 yields Arith_Out=0 with Arith_Flag=1.

Decomposition:
- Package alu_pkg holds:
  - WIDTH default
  - unit-select constants: ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11
  - the sixteen function-code localparams
  - compare result codes: CMP_NONE=0, CMP_EQ=1, CMP_GT=2, CMP_LT=3
- Sub-module alu_decoder: ALU_FUN[3:2] to a one-hot four-bit enable vector.
- The four units live in alu_top as enabled registered processes.

Test Plan:
- Reset: hold rst=0 with A=5, B=3, ALU_FUN=0000 and toggle clk. All outputs and flags stay 0. Release reset; next edge gives Arith_Out=8, Arith_Flag=1.
- Arithmetic, one cycle each:
  - A=-10, B=-5, 0000 -> Arith_Out=-15
  - A=10, B=5, 0001 -> 5
  - A=3, B=4, 0010 -> 12
  - A=20, B=4, 0011 -> 5
  - A=-7, B=2, 0011 -> -3
  - A=7, B=0, 0011 -> 0
  - A=32767, B=1, 0000 -> -32768
- Logic with A=6, B=3:
  - 0100 -> 2
  - 0101 -> 7
  - 0110 -> -3 (16'hFFFD)
  - 0111 -> -8 (16'hFFF8)
  - Logic_Flag=1 and all other flags/outputs 0 in each case.
- Compare:
  - A=6, B=6, 1000 -> 0
  - A=6, B=6, 1001 -> 1
  - A=5, B=1, 1010 -> 2
  - A=7, B=11, 1011 -> 3
  - A=-1, B=1, 1010 -> 0 (signed)
  - A=5, B=6, 1001 -> 0
- Shift:
  - A=4, 1100 -> 2
  - A=8, 1101 -> 16
  - B=1, 1110 -> 0
  - B=1, 1111 -> 2
  - A=-2, 1100 -> 16'h7FFF
- Back-to-back: switch ALU_FUN every cycle across all four units. Each cycle exactly one flag is high; the previously selected unit's output is 0.
